// File: rtl/ins_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch stage (master) and the memory (slave).
// A read completes on a rising edge where mem_read is high and mem_busywait is low.
interface ins_fetch_unit_if;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport master (
        output mem_read,
        output mem_address,
        input  mem_readdata,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_address,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and buffers
// returned words in a small prefetch FIFO; handles stall and branch redirect.
module ins_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [31:0]             branch_target,
    ins_fetch_unit_if.master        mem,
    output logic [31:0]             instr_out,
    output logic [31:0]             pc_out,
    output logic [31:0]             pc_plus4_out,
    output logic                    instr_valid
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        S_FETCH   = 1'b0,
        S_DISCARD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        stale_addr_q, stale_addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_instr_q [FIFO_DEPTH];
    logic [31:0]        fifo_instr_d [FIFO_DEPTH];
    logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]        fifo_pc_d    [FIFO_DEPTH];

    logic               req;
    logic [31:0]        req_addr;
    logic               complete;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic [31:0]        redirect_pc;

    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign redirect_pc = branch_target & 32'hFFFF_FFFC;

    // The request is masked during reset so an in-flight read is simply abandoned.
    assign mem.mem_read    = req & ~reset;
    assign mem.mem_address = req_addr;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        stale_addr_d = stale_addr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        req          = 1'b0;
        req_addr     = fetch_pc_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (state_q == S_DISCARD) begin
            req      = 1'b1;
            req_addr = stale_addr_q;
        end else begin
            req      = ~fifo_full;
            req_addr = fetch_pc_q;
        end

        complete = req & ~mem.mem_busywait;

        if (branch_taken) begin
            // Redirect wins over push/pop; a busy read must still run to completion.
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            if (state_q == S_FETCH) begin
                if (req && mem.mem_busywait) begin
                    state_d      = S_DISCARD;
                    stale_addr_d = fetch_pc_q;
                end
            end else if (complete) begin
                state_d = S_FETCH;
            end
        end else begin
            if (state_q == S_DISCARD) begin
                if (complete) begin
                    state_d = S_FETCH;
                end
            end else begin
                push = complete;
            end

            pop = (count_q != '0) & ~stall;

            if (push) begin
                fifo_instr_d[wr_ptr_q] = mem.mem_readdata;
                fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
                fetch_pc_d             = fetch_pc_q + 32'd4;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
        stale_addr_q <= stale_addr_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

    // Head outputs read zero while empty so the post-reset values are deterministic.
    assign instr_valid  = (count_q != '0);
    assign instr_out    = instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign pc_out       = instr_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    assign pc_plus4_out = pc_out + 32'd4;
endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction memory and feeds the IF/ID pipeline register. It owns the PC and issues one word read at a time over the read/busywait handshake. Returned words are buffered in a small prefetch FIFO, and the stage supports pipeline stall and branch/jump redirect, including the discarding of stale in-flight reads.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset (word aligned)
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  downstream (IF/ID) not ready; head entry held
branch_taken  input  1  redirect request from EX, one-cycle pulse
branch_target  input  32  redirect PC; bits [1:0] ignored, treated as 0
mem_read  output  1  read request to instruction memory
mem_address  output  32  word-aligned fetch address
mem_readdata  input  32  instruction word returned by memory
mem_busywait  input  1  memory busy; access completes when low with mem_read high
instr_out  output  32  instruction at FIFO head
pc_out  output  32  PC of instr_out
pc_plus4_out  output  32  pc_out + 4, modulo 2^32
instr_valid  output  1  FIFO non-empty (head entry valid)

Behaviour:
- Reset is synchronous: at a rising edge with reset=1:
  - fetch_pc <= RESET_PC; FIFO count <= 0; state <= FETCH.
  - Outputs: instr_valid=0, instr_out=0, pc_out=0, pc_plus4_out=4.
- mem_read is forced to 0 while reset=1.
- State machine (2 states):
  - FETCH: mem_read = (count < FIFO_DEPTH); mem_address = fetch_pc.
  - DISCARD: mem_read = 1; mem_address = held stale address. The stale access completes and its data is dropped.
- Completion: a read completes at a rising edge where mem_read=1 and mem_busywait=0. mem_readdata is sampled at that edge. At most one read is outstanding.
- While mem_read=1 and mem_busywait=1, mem_address and mem_read are held stable. A request is never withdrawn before it completes.
- On completion in FETCH with no redirect:
  - push {mem_readdata, fetch_pc} into the FIFO;
  - fetch_pc <= fetch_pc + 4 (wraps 32'hFFFFFFFC -> 0).
- Pop: at an edge with instr_valid=1 and stall=0, the head entry is removed.
- Simultaneous push and pop leaves count unchanged. Push is only possible when count < FIFO_DEPTH, so overflow cannot occur.
- Head outputs are driven from FIFO storage. instr_valid is 1 the cycle after the first push; there is no combinational bypass from mem_readdata.
- Redirect (branch_taken=1 at an edge) has priority over push, pop and stall:
  - FIFO flushed (count <= 0); fetch_pc <= {branch_target[31:2], 2'b00}.
  - If a read is outstanding and not completing that edge (mem_read=1, mem_busywait=1): state <= DISCARD.
  - If a read completes that same edge: its data is dropped and state stays FETCH.
  - If there is no read in flight: state stays FETCH.
  - instr_valid is 0 the cycle after a redirect.
- DISCARD -> FETCH at the completion edge; the data is dropped and fetch_pc is unchanged.
- A further redirect during DISCARD only updates fetch_pc; state stays DISCARD.
- Latency: with zero busywait, the first instruction is valid 2 cycles after reset deasserts. Redirect to valid instruction takes 2 cycles, or 2 + remaining stale busy cycles.
- stall=1 with a full FIFO: mem_read drops to 0 after the current access completes, and the head is held indefinitely.
- Reset mid-access: the in-flight read is abandoned, and mem_read=0 while reset is high.

Test Plan:
- Reset release, memory zero-wait, words 0x00500093,0x00A00113 at 0/4 -> instr_valid=1 two cycles after reset, pc_out=0 instr_out=0x00500093, next cycle pc_out=4.
- Memory busywait 3 cycles per access, stall=0 -> mem_address stable during busy, one instruction per 4 cycles, pc_out sequence 0,4,8,12.
- stall=1 for 6 cycles from first valid -> FIFO fills to 2, mem_read=0 afterwards, pc_out stays 0; release -> pc 4,8 delivered in order with no gap, then fetch at 12 resumes.
- branch_taken with target 0x103 while read of 0x8 is busy -> FIFO flushed, DISCARD until completion, stale word never appears, next pc_out=0x100.
- branch_taken on the same edge as completion at 0x8 -> word at 0x8 dropped, mem_address=0x40 next cycle for target 0x40, instr_valid=0 that cycle.
- RESET_PC=32'hFFFFFFFC -> fetch wraps, pc_out sequence 0xFFFFFFFC,0x0; pc_plus4_out for the first entry = 0.
